// File: rtl/bsg_link_ddr_downstream_rx.sv
// DDR link receive endpoint: pairs two DDR beats into one core word, buffers
// words in a first-word-fall-through FIFO and returns credits as a toggling token.
module bsg_link_ddr_downstream_rx #(
    parameter int channel_width                 = 8,
    parameter int num_channels                  = 2,
    parameter int lg_fifo_depth                 = 3,
    parameter int lg_credit_to_token_decimation = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [num_channels-1:0]                 io_valid_i,
    input  logic [num_channels*channel_width-1:0]   io_data_pos_i,
    input  logic [num_channels*channel_width-1:0]   io_data_neg_i,
    output logic                                    core_valid_o,
    output logic [4*channel_width*num_channels-1:0] core_data_o,
    input  logic                                    core_yumi_i,
    output logic                                    token_o,
    output logic                                    overflow_o,
    output logic                                    misalign_o,
    output logic [lg_fifo_depth:0]                  fifo_count_o
);

    localparam int core_width = 4 * channel_width * num_channels;
    localparam int half_width = core_width / 2;
    localparam int fifo_depth = 1 << lg_fifo_depth;
    localparam logic [lg_fifo_depth:0] depth_count = (lg_fifo_depth + 1)'(fifo_depth);

    typedef enum logic {PH0, PH1} phase_e;

    phase_e                  phase_r, phase_n;
    logic                    all_valid, misalign_event, latch_half, push_req;
    logic                    push, pop;
    logic [half_width-1:0]   beat, half_r;
    logic [core_width-1:0]   mem_r [fifo_depth];
    logic [lg_fifo_depth-1:0] wptr_r, rptr_r;
    logic [lg_fifo_depth:0]  count_r;
    logic [lg_credit_to_token_decimation-1:0] credit_r;
    logic                    token_r, overflow_r, misalign_r;

    assign all_valid      = &io_valid_i;
    assign misalign_event = |io_valid_i && !all_valid;

    // Each channel contributes {neg, pos}; channel c occupies slice c of the beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        beat = '0;
        for (int c = 0; c < num_channels; c++) begin
            beat[c*2*channel_width +: 2*channel_width] =
                {io_data_neg_i[c*channel_width +: channel_width],
                 io_data_pos_i[c*channel_width +: channel_width]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (rst) phase_r <= PH0;
        else     phase_r <= phase_n;
    end

    always_comb begin
        phase_n = phase_r;
        if (misalign_event)  phase_n = PH0;
        else if (all_valid)  phase_n = (phase_r == PH0) ? PH1 : PH0;
    end

    always_comb begin
        latch_half = all_valid && (phase_r == PH0);
        push_req   = all_valid && (phase_r == PH1);
    end

    always_ff @(posedge clk) begin
        if (rst || misalign_event) half_r <= '0;
        else if (latch_half)       half_r <= beat;
    end

    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign pop  = core_yumi_i && (count_r != '0);
    assign push = push_req && ((count_r < depth_count) || core_yumi_i);

    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_r alone decides which entries are valid.
        if (push) mem_r[wptr_r] <= {beat, half_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) wptr_r <= wptr_r + lg_fifo_depth'(1);
            if (pop)  rptr_r <= rptr_r + lg_fifo_depth'(1);
            case ({push, pop})
                2'b10:   count_r <= count_r + (lg_fifo_depth + 1)'(1);
                2'b01:   count_r <= count_r - (lg_fifo_depth + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_r   <= '0;
            token_r    <= 1'b0;
            overflow_r <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            if (pop) begin
                credit_r <= credit_r + lg_credit_to_token_decimation'(1);
                if (credit_r == '1) token_r <= ~token_r;
            end
            if (push_req && !push) overflow_r <= 1'b1;
            if (misalign_event)    misalign_r <= 1'b1;
        end
    end

    assign core_valid_o = (count_r != '0);
    assign core_data_o  = core_valid_o ? mem_r[rptr_r] : '0;
    assign fifo_count_o = count_r;
    assign token_o      = token_r;
    assign overflow_o   = overflow_r;
    assign misalign_o   = misalign_r;

endmodule

// File: tb/tb_bsg_link_ddr_downstream_rx.sv
// Randomized self-checking bench for bsg_link_ddr_downstream_rx against a
// queue-based model, plus directed scenarios with literal expectations.
module tb_bsg_link_ddr_downstream_rx;

    localparam int depth = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  io_valid_i;
    logic [15:0] io_data_pos_i, io_data_neg_i;
    logic        core_yumi_i;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        token_o, overflow_o, misalign_o;
    logic [3:0]  fifo_count_o;

    bsg_link_ddr_downstream_rx dut (
        .clk           (clk),
        .rst           (rst),
        .io_valid_i    (io_valid_i),
        .io_data_pos_i (io_data_pos_i),
        .io_data_neg_i (io_data_neg_i),
        .core_valid_o  (core_valid_o),
        .core_data_o   (core_data_o),
        .core_yumi_i   (core_yumi_i),
        .token_o       (token_o),
        .overflow_o    (overflow_o),
        .misalign_o    (misalign_o),
        .fifo_count_o  (fifo_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of buffered words, a pending low half, total pops for the token.
    logic [63:0] mq[$];
    bit          have_low = 0;
    logic [31:0] low_half = '0;
    int unsigned pops_total = 0;
    bit          m_ovf = 0, m_mis = 0;
    bit          cmp_en = 0;

    function automatic logic [31:0] pack(input logic [15:0] p, input logic [15:0] n);
        logic [31:0] b;
        for (int c = 0; c < 2; c++) b[c*16 +: 16] = {n[c*8 +: 8], p[c*8 +: 8]};
        return b;
    endfunction

    task automatic model_step();
        bit          req;
        logic [63:0] w;
        req = 0;
        w   = '0;
        if (rst) begin
            mq.delete();
            have_low = 0; low_half = '0; pops_total = 0; m_ovf = 0; m_mis = 0;
        end else begin
            if (io_valid_i == 2'b11) begin
                if (!have_low) begin
                    low_half = pack(io_data_pos_i, io_data_neg_i);
                    have_low = 1;
                end else begin
                    w = {pack(io_data_pos_i, io_data_neg_i), low_half};
                    have_low = 0;
                    req = 1;
                end
            end else if (io_valid_i != 2'b00) begin
                m_mis = 1;
                have_low = 0;
            end
            if (core_yumi_i && mq.size() > 0) begin
                void'(mq.pop_front());
                pops_total++;
            end
            if (req) begin
                if (mq.size() < depth) mq.push_back(w);
                else m_ovf = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid",    core_valid_o, mq.size() != 0);
            check("data",     core_data_o,  mq.size() != 0 ? mq[0] : 64'h0);
            check("count",    fifo_count_o, mq.size());
            check("token",    token_o,      (pops_total / 4) % 2);
            check("overflow", overflow_o,   m_ovf);
            check("misalign", misalign_o,   m_mis);
        end
    end

    task automatic drive(input logic [1:0] v, input logic [15:0] p, input logic [15:0] n,
                         input logic y, input logic r);
        io_valid_i = v; io_data_pos_i = p; io_data_neg_i = n; core_yumi_i = y; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input logic y);
        drive(2'b00, 16'($urandom), 16'($urandom), y, 1'b0);
    endtask

    task automatic do_reset();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic send_beat(input logic [31:0] b, input logic y);
        logic [15:0] p, n;
        for (int c = 0; c < 2; c++) begin
            p[c*8 +: 8] = b[c*16 +: 8];
            n[c*8 +: 8] = b[c*16+8 +: 8];
        end
        drive(2'b11, p, n, y, 1'b0);
    endtask

    task automatic push_word(input logic [63:0] w, input logic y0, input logic y1);
        send_beat(w[31:0], y0);
        send_beat(w[63:32], y1);
    endtask

    function automatic logic [63:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    logic [63:0] fw [9];
    logic [63:0] w;

    initial begin
        io_valid_i = '0; io_data_pos_i = '0; io_data_neg_i = '0; core_yumi_i = 0; rst = 1;
        do_reset();
        do_reset();
        cmp_en = 1;
        check("reset_count", fifo_count_o, 0);
        check("reset_valid", core_valid_o, 0);
        check("reset_data",  core_data_o,  0);
        check("reset_token", token_o,      0);

        // Basic word with channel1 listed first in each literal.
        drive(2'b11, 16'h1133, 16'h2244, 1'b0, 1'b0);
        check("basic_no_early_word", core_valid_o, 0);
        drive(2'b11, 16'h5577, 16'h6688, 1'b0, 1'b0);
        check("basic_valid", core_valid_o, 1);
        check("basic_data",  core_data_o,  64'h6655_8877_2211_4433);

        // Idle gap between beats.
        w = rand_word();
        send_beat(w[31:0], 1'b0);
        repeat (3) idle(1'b0);
        send_beat(w[63:32], 1'b0);
        check("gap_count", fifo_count_o, 2);
        idle(1'b1);
        check("gap_word", core_data_o, w);
        idle(1'b1);
        check("gap_drained", fifo_count_o, 0);
        idle(1'b1);
        check("yumi_empty_ignored", fifo_count_o, 0);

        // Fill, push-while-full with pop, then overflow.
        do_reset();
        for (int i = 0; i < 9; i++) fw[i] = rand_word();
        for (int i = 0; i < 8; i++) push_word(fw[i], 1'b0, 1'b0);
        check("fill_count", fifo_count_o, 8);
        push_word(fw[8], 1'b0, 1'b1);
        check("full_pop_count",    fifo_count_o, 8);
        check("full_pop_overflow", overflow_o,   0);
        push_word(rand_word(), 1'b0, 1'b0);
        check("overflow_flag",  overflow_o,   1);
        check("overflow_count", fifo_count_o, 8);
        for (int i = 1; i < 9; i++) begin
            check("pop_order", core_data_o, fw[i]);
            idle(1'b1);
        end
        check("drain_count", fifo_count_o, 0);

        // Token decimation: toggle on the 4th and 8th pop, not after 3 more.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(rand_word(), 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            idle(1'b1);
            check("token_seq", token_o, (k >= 4 && k < 8) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) push_word(rand_word(), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check("token_hold", token_o, 0);
        end

        // Misalign drops the half, then a clean pair realigns; reset clears all.
        do_reset();
        send_beat($urandom, 1'b0);
        drive(2'b01, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        check("misalign_flag",  misalign_o,   1);
        check("misalign_count", fifo_count_o, 0);
        w = rand_word();
        push_word(w, 1'b0, 1'b0);
        check("realign_word", core_data_o, w);
        for (int i = 0; i < 4; i++) push_word(rand_word(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        push_word(rand_word(), 1'b0, 1'b0);
        push_word(rand_word(), 1'b0, 1'b0);
        push_word(rand_word(), 1'b0, 1'b0);
        push_word(rand_word(), 1'b0, 1'b0);
        check("pre_reset_count", fifo_count_o, 5);
        check("pre_reset_token", token_o,      1);
        do_reset();
        check("rst_count",    fifo_count_o, 0);
        check("rst_valid",    core_valid_o, 0);
        check("rst_token",    token_o,      0);
        check("rst_overflow", overflow_o,   0);
        check("rst_misalign", misalign_o,   0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            int unsigned r;
            logic [1:0]  v;
            r = $urandom_range(0, 199);
            if (r < 90)       v = 2'b11;
            else if (r < 196) v = 2'b00;
            else if (r < 198) v = 2'b01;
            else              v = 2'b10;
            drive(v, 16'($urandom), 16'($urandom), ($urandom_range(0, 4) < 2),
                  ($urandom_range(0, 249) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bsg_link_ddr_downstream_rx.md
Name: bsg_link_ddr_downstream_rx

Overview:
- Receive-side endpoint of the DDR source-synchronous link, i.e. the counterpart of the upstream transmitter.
- Runs on the io clock, after the pad capture stage has split each channel into posedge and negedge bytes.
- Reassembles two beats of num_channels x DDR data into one core word and buffers words in a first-word-fall-through FIFO.
- Returns credits to the upstream as a toggling token, one toggle per 2^lg_credit_to_token_decimation words consumed by the core.

Parameters:
- channel_width, 8, bits per channel per clock edge.
- num_channels, 2, number of DDR channels.
- lg_fifo_depth, 3, log2 of receive FIFO depth (8 words).
- lg_credit_to_token_decimation, 2, token toggles once per 4 words popped.
- core_width, derived = 4*channel_width*num_channels (64); not overridable.

Ports:
- clk  in  1  io clock.
- rst  in  1  reset: synchronous, active-high. Clock is clk.
- io_valid_i  in  num_channels  per-channel beat valid.
- io_data_pos_i  in  num_channels*channel_width  posedge byte per channel; channel c at [c*cw +: cw].
- io_data_neg_i  in  num_channels*channel_width  negedge byte per channel.
- core_valid_o  out  1  FIFO head valid.
- core_data_o  out  core_width  FIFO head word.
- core_yumi_i  in  1  core consumes head this cycle.
- token_o  out  1  credit token; toggles, level is meaningless.
- overflow_o  out  1  sticky: a word arrived while the FIFO was full.
- misalign_o  out  1  sticky: channel valids disagreed.
- fifo_count_o  out  lg_fifo_depth+1  current occupancy.

Behaviour:
- Beat packing: beat[c*2cw +: 2cw] = {neg_c, pos_c}. Word = {beat1, beat0}; beat0 is the first-received beat and sits in the low 32 bits.
- Phase register, 2 states:
  - PH0 (expect low half): on a cycle with all io_valid_i = 1, latch beat0 into the half register and go to PH1.
  - PH1 (expect high half): on a cycle with all io_valid_i = 1, form the word, request a push, and return to PH0.
  - io_valid_i all zero: hold state.
- Misalignment: io_valid_i neither all-0 nor all-1 in either phase → set misalign_o, drop the beat, go to PH0, drop any latched half.
- Push:
  - Accepted if count < depth, or if count == depth and core_yumi_i is asserted in the same cycle.
  - Otherwise the word is dropped, overflow_o is set, and the phase still returns to PH0.
- FIFO:
  - Registered write; the word is visible on core_data_o with core_valid_o = 1 the cycle after the PH1 beat (latency 1).
  - core_valid_o = (count != 0). core_data_o = head word when valid, forced to 0 when empty.
  - Pop on core_yumi_i & core_valid_o. core_yumi_i while empty is ignored: count and pointers unchanged, no credit.
  - Simultaneous push and pop: count unchanged, pointers both advance, including at count == depth.
  - Pointers wrap modulo depth. fifo_count_o is exact in the range 0..depth.
- Token:
  - Credit counter of width lg_credit_to_token_decimation increments on each pop.
  - On wrap from 2^d-1 to 0, token_o toggles, registered on the same clock edge as the pop.
  - Never toggles without pops.
- Reset values: PH0, half register 0, count/pointers 0, core_valid_o 0, core_data_o 0, token_o 0, overflow_o 0, misalign_o 0, credit counter 0, fifo_count_o 0.
- Reset mid-operation: any partial half-word and all buffered words are discarded, pending credits are lost, and sticky flags are cleared. The upstream link is reset with the same rst.
- Sticky flags clear only on rst.

Test Plan:
- Basic word:
  - Stimulus: reset; beat0 valid=2'b11, pos={8'h11,8'h33}, neg={8'h22,8'h44} (channel1 listed first); beat1 pos={8'h55,8'h77}, neg={8'h66,8'h88}.
  - Required response: one cycle after beat1, core_valid_o=1 and core_data_o=64'h6655_8877_2211_4433.
- Idle gap between beats: beat0, 3 cycles io_valid_i=0, beat1 → same single word, no extra word, phase correct.
- Fill and overflow:
  - Push 8 words with core_yumi_i=0 → fifo_count_o=8.
  - A 9th word → dropped, overflow_o=1, count stays 8.
  - Pop all 8 → the 8 data values come out in push order.
- Full with simultaneous pop: at count=8, push a word while asserting core_yumi_i → word accepted, count stays 8, overflow_o stays 0.
- Token decimation:
  - Pop 4 words → token_o 0→1 on the 4th pop edge.
  - Pop 4 more → token_o returns to 0.
  - Pop 3 → no toggle.
- Misalign and reset:
  - io_valid_i=2'b01 in PH1 after a good beat0 → misalign_o=1, no word pushed.
  - The next two good beats → a correct word.
  - Assert rst with 5 words buffered → next cycle count=0, core_valid_o=0, all flags and token_o = 0.
